// File: rtl/psimd_writeback.sv
// Write-back stage for the packed-SIMD unit: buffers up to two execution results
// and streams them to the register file (one beat for FP, two beats for integer pairs).
module psimd_writeback #(
    parameter int REG_WIDTH = 64,
    parameter int ADDR_W    = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ADDR_W-1:0]    in_rd,
    input  logic                 in_int,
    input  logic                 in_flag_en,
    input  logic [REG_WIDTH-1:0] dataout_1,
    input  logic [REG_WIDTH-1:0] dataouti_0,
    input  logic [REG_WIDTH-1:0] dataouti_1,
    input  logic [3:0]           invalid,
    input  logic [3:0]           div_by_zero,
    input  logic [3:0]           overflow,
    input  logic [3:0]           underflow,
    input  logic [3:0]           inexact,
    output logic                 wr_valid,
    input  logic                 wr_ready,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [REG_WIDTH-1:0] wr_data,
    output logic [4:0]           fflags,
    input  logic                 fflags_clr,
    output logic                 busy
);

    typedef enum logic {ST_LO = 1'b0, ST_HI = 1'b1} state_t;

    logic [ADDR_W-1:0]    r_rd [2];
    logic                 r_int [2];
    logic [REG_WIDTH-1:0] r_d0 [2];
    logic [REG_WIDTH-1:0] r_d1 [2];
    logic                 r_wptr;
    logic                 r_rptr;
    logic [1:0]           r_count;
    state_t               r_state;
    state_t               w_state_next;
    logic [4:0]           r_fflags;
    logic [4:0]           w_fflags_next;
    logic [4:0]           w_lane_flags;
    logic                 w_push;
    logic                 w_pop;

    // No bypass: a full FIFO refuses input even while it pops.
    assign in_ready = !rst && (r_count != 2'd2);
    assign w_push   = in_valid && in_ready;
    assign wr_valid = (r_count != 2'd0);
    assign busy     = wr_valid;
    assign fflags   = r_fflags;

    // Entry storage; FP results reuse the low-half slot.
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (w_push && (r_wptr == 1'(gi))) begin
                r_rd[gi]  <= in_rd;
                r_int[gi] <= in_int;
                r_d0[gi]  <= in_int ? dataouti_0 : dataout_1;
                r_d1[gi]  <= dataouti_1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) r_wptr <= ~r_wptr;
            if (w_pop)  r_rptr <= ~r_rptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_LO;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_LO: if (wr_valid && wr_ready && r_int[r_rptr]) w_state_next = ST_HI;
            ST_HI: if (wr_ready) w_state_next = ST_LO;
            default: w_state_next = ST_LO;
        endcase
    end

    always_comb begin
        wr_addr = '0;
        wr_data = '0;
        w_pop   = 1'b0;
        if (wr_valid) begin
            if (r_state == ST_HI) begin
                wr_addr = r_rd[r_rptr] + ADDR_W'(1);
                wr_data = r_d1[r_rptr];
                w_pop   = wr_ready;
            end else begin
                wr_addr = r_rd[r_rptr];
                wr_data = r_d0[r_rptr];
                w_pop   = wr_ready && !r_int[r_rptr];
            end
        end
    end

    assign w_lane_flags = {|invalid, |div_by_zero, |overflow, |underflow, |inexact};

    // New flags from an accepted result take priority over a simultaneous clear.
    always_comb begin
        w_fflags_next = r_fflags;
        if (w_push && in_flag_en)
            w_fflags_next = (fflags_clr ? 5'd0 : r_fflags) | w_lane_flags;
        else if (fflags_clr)
            w_fflags_next = 5'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_fflags <= 5'd0;
        else     r_fflags <= w_fflags_next;
    end

endmodule
